multi_input_capture: RTL and testbench
======================================

Name: multi_input_capture

Overview:
Scans NUM_CH ADC channels round-robin by driving the channel-select output. It captures each returned sample into a per-channel register and optionally smooths it with a shift-based IIR filter. Each channel drives its own glitch-free PWM output from one shared counter. Sits between the AVR/ADC sample interface and the board LEDs, and generalises single-channel A0 capture to N channels with filtering and timeout recovery.

Parameters:
NUM_CH, 8, number of scanned channels (1..16), scanning indices 0..NUM_CH-1
SAMPLE_W, 10, ADC sample width and PWM resolution
FILT_SHIFT, 2, IIR smoothing shift k (alpha = 2^-k); 0 = no filtering
TIMEOUT, 4096, cycles to wait for a matching sample before skipping the channel (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  scan enable; 0 holds the scanner in IDLE
channel  out  4  ADC channel requested (current scan index)
new_sample  in  1  one-cycle strobe: sample/sample_channel valid
sample  in  SAMPLE_W  ADC result
sample_channel  in  4  channel the sample belongs to
value  out  NUM_CH*SAMPLE_W  filtered value per channel; ch i at bits [i*SAMPLE_W +: SAMPLE_W]
valid  out  NUM_CH  bit i set once channel i has received at least one sample
pwm  out  NUM_CH  per-channel PWM
scan_done  out  1  one-cycle pulse when the scan index wraps from NUM_CH-1 to 0
timeout_err  out  1  sticky; set on any channel timeout; cleared by rst only

Behaviour:
- Reset: channel=0, value=0, valid=0, pwm=0, scan_done=0, timeout_err=0, state=IDLE, PWM counter=0, timeout counter=0, all accumulators 0.
- FSM states: IDLE, WAIT, UPDATE.
  - IDLE -> WAIT when en=1. Timeout counter cleared.
  - WAIT: accept only if new_sample=1 and sample_channel==channel. Latch sample, go to UPDATE. Non-matching strobes are ignored and do not reset the timeout counter.
  - WAIT with no match: timeout counter increments each cycle. When it reaches TIMEOUT-1 with no match, set timeout_err, advance index, stay in WAIT, clear the counter. value/valid of the skipped channel are unchanged.
  - UPDATE (1 cycle): write the filter for the current index, advance index, clear the counter. Go to WAIT if en=1, else IDLE.
  - en=0 in WAIT: return to IDLE at the next edge; index held.
- Index advance: idx+1, wrapping NUM_CH-1 -> 0. scan_done pulses on the cycle after any wrap, whether by UPDATE or by timeout. channel = index, zero-extended to 4 bits.
- Filter: per-channel accumulator acc of width SAMPLE_W+FILT_SHIFT.
  - First sample (valid[i]=0): acc = s<<k and valid[i] set.
  - Otherwise: acc = acc - (acc>>k) + s.
  - value[i] = acc>>k (truncated); registered, updated at the end of UPDATE.
  - Steady constant input s yields value = s exactly. No overflow is possible by construction.
  - k=0 gives value = last sample.
- Latency: a matching strobe at cycle T gives value visible at T+2.
- PWM:
  - Shared free-running SAMPLE_W-bit counter.
  - Per-channel compare register loads value[i] only when the counter == all-ones, so it is glitch-free at period boundaries.
  - pwm[i] = registered (counter < compare[i]).
  - 0 -> constant low; all-ones -> high 2^W-1 of 2^W cycles.
- Simultaneous events:
  - A matching strobe on the same cycle as timeout expiry is accepted (match wins); no timeout_err.
  - A strobe during UPDATE or IDLE is ignored.
- rst mid-operation returns everything to reset values at the next edge, including valid and accumulators.

Test Plan:
- Reset then en=1, NUM_CH=4: channel sequences 0,1,2,3,0 as matching strobes are returned one per 10 cycles -> scan_done pulses exactly once per wrap; valid=4'b1111 after the first scan.
- k=2, ch0 receives 400 then repeated 0 -> value[0] = 400, 300, 225, 168 (truncated); constant 512 from reset -> 512 immediately and held.
- Strobes with sample_channel != channel (e.g. 3 while channel=1) -> ignored; value unchanged; timeout counter keeps running.
- No strobes for TIMEOUT cycles on ch2 -> timeout_err=1, channel advances to 3, value[2]/valid[2] unchanged; matching strobe on the expiry cycle -> accepted, no error.
- value[1]=256, W=10 -> pwm[1] high 256 of every 1024 cycles. Change value mid-period -> duty changes only at the next period start. value 0 -> never high.
- Assert rst while in WAIT with valid partially set -> all outputs at reset values on the next cycle; scanning restarts at channel 0.

Source files
------------

// File: rtl/multi_input_capture_if.sv
// Sample-side and LED-side signals of the multi-channel capture block.
// The master drives the ADC handshake; the slave is the capture block.
interface multi_input_capture_if #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned SAMPLE_W = 10
);
  logic                       en;
  logic [3:0]                 channel;
  logic                       new_sample;
  logic [SAMPLE_W-1:0]        sample;
  logic [3:0]                 sample_channel;
  logic [NUM_CH*SAMPLE_W-1:0] value;
  logic [NUM_CH-1:0]          valid;
  logic [NUM_CH-1:0]          pwm;
  logic                       scan_done;
  logic                       timeout_err;

  modport master (
    output en, new_sample, sample, sample_channel,
    input  channel, value, valid, pwm, scan_done, timeout_err
  );

  modport slave (
    input  en, new_sample, sample, sample_channel,
    output channel, value, valid, pwm, scan_done, timeout_err
  );
endinterface

// File: rtl/multi_input_capture.sv
// Round-robin ADC channel scanner with per-channel IIR smoothing, timeout skip and
// glitch-free per-channel PWM driven from one shared counter.
module multi_input_capture #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned SAMPLE_W   = 10,
  parameter int unsigned FILT_SHIFT = 2,
  parameter int unsigned TIMEOUT    = 4096
) (
  input logic                  clk,
  input logic                  rst,
  multi_input_capture_if.slave bus
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AccW = SAMPLE_W + FILT_SHIFT;
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StWait, StUpdate} state_e;

  state_e                     state_q;
  logic [IdxW-1:0]            idx_q;
  logic [CntW-1:0]            tmo_q;
  logic [SAMPLE_W-1:0]        samp_q;
  logic [AccW-1:0]            acc_q [NUM_CH];
  logic [NUM_CH*SAMPLE_W-1:0] value_q;
  logic [NUM_CH-1:0]          valid_q;
  logic                       scan_done_q;
  logic                       timeout_err_q;

  logic [SAMPLE_W-1:0]        pwm_cnt_q;
  logic [SAMPLE_W-1:0]        cmp_q [NUM_CH];
  logic [NUM_CH-1:0]          pwm_q;

  logic                       match;
  logic                       idx_wrap;
  logic [IdxW-1:0]            idx_next;
  logic [AccW-1:0]            acc_cur;
  logic [AccW-1:0]            acc_new;

  always_comb begin
    match    = bus.new_sample && (bus.sample_channel == 4'(idx_q));
    idx_wrap = (idx_q == IdxLast);
    idx_next = idx_wrap ? '0 : idx_q + 1'b1;
    acc_cur  = acc_q[idx_q];
    // First sample preloads the accumulator so the output settles immediately.
    acc_new  = valid_q[idx_q] ? acc_cur - (acc_cur >> FILT_SHIFT) + AccW'(samp_q)
                              : AccW'(samp_q) << FILT_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      tmo_q         <= '0;
      samp_q        <= '0;
      value_q       <= '0;
      valid_q       <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q <= StWait;
            tmo_q   <= '0;
          end
        end
        StWait: begin
          if (!bus.en) begin
            state_q <= StIdle;
          end else if (match) begin
            samp_q  <= bus.sample;
            state_q <= StUpdate;
          end else if (tmo_q == TmoLast) begin
            timeout_err_q <= 1'b1;
            idx_q         <= idx_next;
            scan_done_q   <= idx_wrap;
            tmo_q         <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StUpdate: begin
          acc_q[idx_q]                         <= acc_new;
          valid_q[idx_q]                       <= 1'b1;
          value_q[idx_q*SAMPLE_W +: SAMPLE_W]  <= SAMPLE_W'(acc_new >> FILT_SHIFT);
          idx_q                                <= idx_next;
          scan_done_q                          <= idx_wrap;
          tmo_q                                <= '0;
          state_q                              <= bus.en ? StWait : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Compare registers only reload at the period boundary so duty never glitches mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (&pwm_cnt_q) cmp_q[i] <= value_q[i*SAMPLE_W +: SAMPLE_W];
        pwm_q[i] <= (pwm_cnt_q < cmp_q[i]);
      end
    end
  end

  assign bus.channel     = 4'(idx_q);
  assign bus.value       = value_q;
  assign bus.valid       = valid_q;
  assign bus.pwm         = pwm_q;
  assign bus.scan_done   = scan_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_multi_input_capture.sv
// Randomised bench for multi_input_capture, checked against an arithmetic model of
// the scan order, IIR filter, timeout skip and PWM duty.
module tb_multi_input_capture;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned SAMPLE_W   = 10;
  localparam int unsigned FILT_SHIFT = 2;
  localparam int unsigned TIMEOUT    = 64;
  localparam int unsigned PERIOD     = 1 << SAMPLE_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_input_capture_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

  multi_input_capture #(
    .NUM_CH    (NUM_CH),
    .SAMPLE_W  (SAMPLE_W),
    .FILT_SHIFT(FILT_SHIFT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  int m_idx;
  int m_acc   [NUM_CH];
  bit m_valid [NUM_CH];
  bit m_err;
  int m_wraps = 0;

  int          sd_cnt = 0;
  int unsigned cyc    = 0;
  always @(negedge clk) if (bus.scan_done === 1'b1) sd_cnt++;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic void m_reset();
    m_idx = 0;
    m_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i]   = 0;
      m_valid[i] = 1'b0;
    end
  endfunction

  function automatic void m_advance();
    m_idx = (m_idx + 1) % NUM_CH;
    if (m_idx == 0) m_wraps++;
  endfunction

  function automatic void m_accept(input int s);
    if (!m_valid[m_idx]) m_acc[m_idx] = s * (1 << FILT_SHIFT);
    else m_acc[m_idx] = m_acc[m_idx] - m_acc[m_idx] / (1 << FILT_SHIFT) + s;
    m_valid[m_idx] = 1'b1;
    m_advance();
  endfunction

  function automatic int m_value(input int ch);
    return m_acc[ch] / (1 << FILT_SHIFT);
  endfunction

  function automatic logic [NUM_CH-1:0] m_valid_vec();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [SAMPLE_W-1:0] dut_value(input int ch);
    return bus.value[ch*SAMPLE_W +: SAMPLE_W];
  endfunction

  task automatic do_reset();
    bus.en         = 1'b0;
    bus.new_sample = 1'b0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic start_scan();
    bus.en = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input int ch, input int s);
    bus.sample_channel = 4'(ch);
    bus.sample         = SAMPLE_W'(s);
    bus.new_sample     = 1'b1;
    @(negedge clk);
    bus.new_sample = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_phase();
    int n = 0;
    while ((cyc % PERIOD) != 1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((cyc % PERIOD) != 1) begin
      errors++;
      $display("FAIL pwm_phase_wait: got phase %0d, expected 1", cyc % PERIOD);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 6;
    if (bus.channel !== 4'd0) begin errors++; $display("FAIL reset_channel: got %0d, expected 0", bus.channel); end
    if (bus.value !== '0) begin errors++; $display("FAIL reset_value: got %h, expected 0", bus.value); end
    if (bus.valid !== '0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.valid); end
    if (bus.pwm !== '0) begin errors++; $display("FAIL reset_pwm: got %b, expected 0", bus.pwm); end
    if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done: got %b, expected 0", bus.scan_done); end
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b, expected 0", bus.timeout_err); end
    // Strobe while idle must be ignored
    strobe(0, 123);
    checks += 2;
    if (bus.valid !== '0) begin errors++; $display("FAIL idle_strobe_valid: got %b, expected 0", bus.valid); end
    if (dut_value(0) !== '0) begin errors++; $display("FAIL idle_strobe_value: got %0d, expected 0", dut_value(0)); end
  endtask

  task automatic test_filter();
    int seq0 [4] = '{400, 0, 0, 0};
    int exp0 [4] = '{400, 300, 225, 168};
    int sd_base, s;
    do_reset();
    start_scan();
    sd_base = sd_cnt;
    for (int scan = 0; scan < 4; scan++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        s = (ch == 0) ? seq0[scan] : (ch == 1) ? 512 : int'($urandom_range(0, PERIOD - 1));
        if (scan == 0 && ch == 0) begin
          bus.sample_channel = 4'd0;
          bus.sample         = SAMPLE_W'(s);
          bus.new_sample     = 1'b1;
          @(negedge clk);
          bus.new_sample = 1'b0;
          checks++;
          if (dut_value(0) !== '0) begin
            errors++; $display("FAIL latency_early: got %0d, expected 0", dut_value(0));
          end
          @(negedge clk);
        end else begin
          strobe(ch, s);
        end
        m_accept(s);
        checks += 3;
        if (dut_value(ch) !== SAMPLE_W'(m_value(ch))) begin
          errors++; $display("FAIL filter_value[%0d]: got %0d, expected %0d", ch, dut_value(ch), m_value(ch));
        end
        if (bus.channel !== 4'(m_idx)) begin
          errors++; $display("FAIL filter_channel: got %0d, expected %0d", bus.channel, m_idx);
        end
        if (bus.scan_done !== (m_idx == 0)) begin
          errors++; $display("FAIL filter_scan_done: got %b, expected %b", bus.scan_done, m_idx == 0);
        end
        if (ch == 0) begin
          checks++;
          if (dut_value(0) !== SAMPLE_W'(exp0[scan])) begin
            errors++; $display("FAIL decay_ch0 step %0d: got %0d, expected %0d", scan, dut_value(0), exp0[scan]);
          end
        end
        if (ch == 1) begin
          checks++;
          if (dut_value(1) !== SAMPLE_W'(512)) begin
            errors++; $display("FAIL const_ch1: got %0d, expected 512", dut_value(1));
          end
        end
        repeat (8) @(negedge clk);
      end
      checks += 2;
      if (bus.valid !== 4'b1111) begin errors++; $display("FAIL scan_valid: got %b, expected 1111", bus.valid); end
      if (sd_cnt - sd_base !== scan + 1) begin
        errors++; $display("FAIL scan_done_count: got %0d, expected %0d", sd_cnt - sd_base, scan + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sd_base, w_base, s, g, wc;
    sd_base = sd_cnt;
    w_base  = m_wraps;
    for (int n = 0; n < 3 * NUM_CH; n++) begin
      g = int'($urandom_range(0, 10));
      for (int t = 0; t < g; t++) begin
        wc = int'($urandom_range(0, 15));
        if (wc == m_idx) wc = (wc + 1) % 16;
        bus.sample_channel = 4'(wc);
        bus.sample         = SAMPLE_W'($urandom_range(0, PERIOD - 1));
        bus.new_sample     = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.new_sample = 1'b0;
      s = int'($urandom_range(0, PERIOD - 1));
      strobe(m_idx, s);
      m_accept(s);
      checks += 2;
      for (int i = 0; i < NUM_CH; i++) begin
        checks++;
        if (dut_value(i) !== SAMPLE_W'(m_value(i))) begin
          errors++; $display("FAIL rand_value[%0d]: got %0d, expected %0d", i, dut_value(i), m_value(i));
        end
      end
      if (bus.channel !== 4'(m_idx)) begin
        errors++; $display("FAIL rand_channel: got %0d, expected %0d", bus.channel, m_idx);
      end
      if (bus.valid !== m_valid_vec()) begin
        errors++; $display("FAIL rand_valid: got %b, expected %b", bus.valid, m_valid_vec());
      end
    end
    @(negedge clk);
    checks++;
    if (sd_cnt - sd_base !== m_wraps - w_base) begin
      errors++; $display("FAIL rand_scan_done_count: got %0d, expected %0d", sd_cnt - sd_base, m_wraps - w_base);
    end
  endtask

  task automatic test_expiry_match();
    int s;
    do_reset();
    start_scan();
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (bus.channel !== 4'd0) begin
      errors++; $display("FAIL expiry_early_channel: got %0d, expected 0", bus.channel);
    end
    s = int'($urandom_range(1, PERIOD - 1));
    strobe(0, s);
    m_accept(s);
    checks += 3;
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL expiry_match_err: got %b, expected 0", bus.timeout_err); end
    if (bus.channel !== 4'd1) begin errors++; $display("FAIL expiry_match_channel: got %0d, expected 1", bus.channel); end
    if (dut_value(0) !== SAMPLE_W'(s)) begin errors++; $display("FAIL expiry_match_value: got %0d, expected %0d", dut_value(0), s); end
  endtask

  task automatic test_timeout();
    int s;
    logic [SAMPLE_W-1:0] v2;
    for (int n = 0; n < 5; n++) begin
      s = int'($urandom_range(0, PERIOD - 1));
      strobe(m_idx, s);
      m_accept(s);
    end
    v2 = SAMPLE_W'(m_value(2));
    for (int t = 0; t < int'(TIMEOUT) - 1; t++) begin
      bus.sample_channel = 4'($urandom_range(3, 15));
      bus.sample         = SAMPLE_W'($urandom_range(0, PERIOD - 1));
      bus.new_sample     = (t < int'(TIMEOUT) / 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.new_sample = 1'b0;
    checks += 3;
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early_err: got %b, expected 0", bus.timeout_err); end
    if (bus.channel !== 4'd2) begin errors++; $display("FAIL timeout_early_channel: got %0d, expected 2", bus.channel); end
    if (dut_value(2) !== v2) begin errors++; $display("FAIL wrong_ch_value: got %0d, expected %0d", dut_value(2), v2); end
    @(negedge clk);
    m_err = 1'b1;
    m_advance();
    checks += 4;
    if (bus.timeout_err !== m_err) begin errors++; $display("FAIL timeout_err: got %b, expected 1", bus.timeout_err); end
    if (bus.channel !== 4'(m_idx)) begin errors++; $display("FAIL timeout_channel: got %0d, expected %0d", bus.channel, m_idx); end
    if (dut_value(2) !== v2) begin errors++; $display("FAIL timeout_value2: got %0d, expected %0d", dut_value(2), v2); end
    if (bus.valid !== m_valid_vec()) begin errors++; $display("FAIL timeout_valid: got %b, expected %b", bus.valid, m_valid_vec()); end
    // Silent channel 3 times out and wraps the scan
    repeat (TIMEOUT) @(negedge clk);
    m_advance();
    checks += 2;
    if (bus.channel !== 4'(m_idx)) begin errors++; $display("FAIL timeout_wrap_channel: got %0d, expected %0d", bus.channel, m_idx); end
    if (bus.scan_done !== 1'b1) begin errors++; $display("FAIL timeout_wrap_scan_done: got %b, expected 1", bus.scan_done); end
  endtask

  task automatic test_pwm();
    int hi0, hi1, hi2;
    do_reset();
    start_scan();
    strobe(0, 0);    m_accept(0);
    strobe(1, 256);  m_accept(256);
    strobe(2, 1023); m_accept(1023);
    strobe(3, 77);   m_accept(77);
    strobe(0, 0);    m_accept(0);
    bus.en = 1'b0;
    @(negedge clk);
    wait_phase();
    repeat (PERIOD) @(negedge clk);
    hi0 = 0; hi1 = 0; hi2 = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      if (bus.pwm[0]) hi0++;
      if (bus.pwm[1]) hi1++;
      if (bus.pwm[2]) hi2++;
      @(negedge clk);
    end
    checks += 3;
    if (hi0 !== 0) begin errors++; $display("FAIL pwm_zero: got %0d high cycles, expected 0", hi0); end
    if (hi1 !== 256) begin errors++; $display("FAIL pwm_256: got %0d high cycles, expected 256", hi1); end
    if (hi2 !== m_value(2)) begin errors++; $display("FAIL pwm_full: got %0d high cycles, expected %0d", hi2, m_value(2)); end
    // Raise value[1] mid-period: this period must keep the old duty
    hi1 = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      if (bus.pwm[1]) hi1++;
      if (i == 300) bus.en = 1'b1;
      if (i == 301) begin
        bus.sample_channel = 4'd1;
        bus.sample         = SAMPLE_W'(1023);
        bus.new_sample     = 1'b1;
      end
      if (i == 302) bus.new_sample = 1'b0;
      if (i == 304) bus.en = 1'b0;
      @(negedge clk);
    end
    m_accept(1023);
    checks += 2;
    if (hi1 !== 256) begin errors++; $display("FAIL pwm_mid_period: got %0d high cycles, expected 256", hi1); end
    if (dut_value(1) !== SAMPLE_W'(m_value(1))) begin
      errors++; $display("FAIL pwm_new_value: got %0d, expected %0d", dut_value(1), m_value(1));
    end
    hi1 = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      if (bus.pwm[1]) hi1++;
      @(negedge clk);
    end
    checks++;
    if (hi1 !== m_value(1)) begin errors++; $display("FAIL pwm_next_period: got %0d high cycles, expected %0d", hi1, m_value(1)); end
  endtask

  task automatic test_rst_mid();
    int s;
    do_reset();
    start_scan();
    repeat (TIMEOUT) @(negedge clk);
    m_err = 1'b1;
    m_advance();
    s = int'($urandom_range(0, PERIOD - 1)); strobe(1, s); m_accept(s);
    s = int'($urandom_range(0, PERIOD - 1)); strobe(2, s); m_accept(s);
    checks += 2;
    if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL pre_rst_err: got %b, expected 1", bus.timeout_err); end
    if (bus.valid !== m_valid_vec()) begin errors++; $display("FAIL pre_rst_valid: got %b, expected %b", bus.valid, m_valid_vec()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    checks += 6;
    if (bus.channel !== 4'd0) begin errors++; $display("FAIL rst_mid_channel: got %0d, expected 0", bus.channel); end
    if (bus.value !== '0) begin errors++; $display("FAIL rst_mid_value: got %h, expected 0", bus.value); end
    if (bus.valid !== '0) begin errors++; $display("FAIL rst_mid_valid: got %b, expected 0", bus.valid); end
    if (bus.pwm !== '0) begin errors++; $display("FAIL rst_mid_pwm: got %b, expected 0", bus.pwm); end
    if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL rst_mid_scan_done: got %b, expected 0", bus.scan_done); end
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b, expected 0", bus.timeout_err); end
    @(negedge clk);
    s = int'($urandom_range(1, PERIOD - 1));
    strobe(0, s);
    m_accept(s);
    checks += 3;
    if (bus.channel !== 4'd1) begin errors++; $display("FAIL rst_restart_channel: got %0d, expected 1", bus.channel); end
    if (dut_value(0) !== SAMPLE_W'(s)) begin errors++; $display("FAIL rst_restart_value: got %0d, expected %0d", dut_value(0), s); end
    if (bus.valid !== m_valid_vec()) begin errors++; $display("FAIL rst_restart_valid: got %b, expected %b", bus.valid, m_valid_vec()); end
  endtask

  initial begin
    bus.en             = 1'b0;
    bus.new_sample     = 1'b0;
    bus.sample         = '0;
    bus.sample_channel = '0;
    m_reset();
    test_reset();
    test_filter();
    test_back_to_back();
    test_expiry_match();
    test_timeout();
    test_pwm();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
